booth_mult_seq: RTL and testbench

//  Iterative radix-2 Booth multiplier for the KGP_RISC execute stage: signed 32x32 -> 64-bit product.
//  It sits directly upstream of the shared 32-bit Adder. Every cycle it drives the adder's A, B and cin,
//  and it consumes sum/of on the same cycle. It contains no adder of its own.
//  A start/busy/done handshake lets the control unit stall the pipeline while the multiply runs.

---
 rtl/booth_mult_seq.sv | 127 ++++++++++++
 tb/tb_booth_mult_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier (signed WIDTH x WIDTH -> 2*WIDTH) driving the shared adder.
// Optional MULT_ABORT_EN adds an `abort` input that cancels a running multiply.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
`ifdef MULT_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_of
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_1;
  logic [CW-1:0]    count;

  logic             sgn;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] q_nx;
  logic             last;
  logic             kill;
  logic             accept;

`ifdef MULT_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    add_a   = acc;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      unique case ({q[0], q_1})
        2'b10: begin
          add_b   = ~m;
          add_cin = 1'b1;
        end
        2'b01: add_b = m;
        default: ;
      endcase
    end
  end

  // sum^of recovers the true sign of the W+1-bit result (needed for M = most negative)
  assign sgn    = add_sum[WIDTH-1] ^ add_of;
  assign acc_nx = {sgn, add_sum[WIDTH-1:1]};
  assign q_nx   = {add_sum[0], q[WIDTH-1:1]};
  assign last   = (count == CW'(WIDTH - 1));
  assign accept = start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (accept) begin
      m     <= mcand;
      q     <= mplier;
      acc   <= '0;
      q_1   <= 1'b0;
      count <= '0;
      state <= RUN;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_nx;
            q   <= q_nx;
            q_1 <= q[0];
            if (last) begin
              product <= {acc_nx, q_nx};
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq with a behavioural adder and a signed-multiply reference.
// Directed handshake/boundary steps plus randomized operands.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_of;
`ifdef MULT_ABORT_EN
  logic        abort;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Shared adder: A + B + cin with signed overflow flag
  assign add_sum = add_a + add_b + {31'b0, add_cin};
  assign add_of  = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
`ifdef MULT_ABORT_EN
    .abort   (abort),
`endif
    .busy    (busy),
    .done    (done),
    .product (product),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .add_of  (add_of)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return 64'(x);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an operation and wait (bounded) for done; returns busy-cycle count
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int bc, output bit seen);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    tick();
    start = 1'b0;
    bc    = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bc++;
      tick();
    end
  endtask

  int bc;
  bit seen;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
`ifdef MULT_ABORT_EN
    abort  = 1'b0;
`endif
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_add_b", 64'(add_b), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: 7 * -3
    run_op(32'd7, 32'hFFFF_FFFD, bc, seen);
    chk("t1_done_seen", 64'(seen), 64'd1);
    chk("t1_busy_cycles", 64'(bc), 64'd32);
    chk("t1_product", product, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_cin", 64'(add_cin), 64'd0);
    chk("t1_product_held", product, 64'hFFFF_FFFF_FFFF_FFEB);

    // 2: most negative squared
    run_op(32'h8000_0000, 32'h8000_0000, bc, seen);
    chk("t2_done_seen", 64'(seen), 64'd1);
    chk("t2_product", product, 64'h4000_0000_0000_0000);
    tick();

    // 3: back-to-back
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, seen);
    chk("t3a_done_seen", 64'(seen), 64'd1);
    chk("t3a_product", product, 64'd1);
    run_op(32'h0001_0000, 32'h0001_0000, bc, seen);
    chk("t3b_done_seen", 64'(seen), 64'd1);
    chk("t3b_busy_cycles", 64'(bc), 64'd32);
    chk("t3b_product", product, 64'h0000_0001_0000_0000);
    tick();

    // 4: start during RUN is ignored
    mcand  = 32'd123;
    mplier = 32'hFFFF_FE38;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    mcand  = 32'd999;
    mplier = 32'd777;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_busy_still", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("t4_done_seen", 64'(seen), 64'd1);
    chk("t4_product", product, ref_mul(32'd123, 32'hFFFF_FE38));
    tick();

    // 5: async reset mid-run
    mcand  = 32'h1234_5678;
    mplier = 32'h0000_0123;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_product", product, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_done", 64'(done), 64'd0);
    run_op(32'd5, 32'd6, bc, seen);
    chk("t5_done_seen", 64'(seen), 64'd1);
    chk("t5_product", product, 64'd30);
    tick();

`ifdef MULT_ABORT_EN
    // 6: abort mid-run
    mcand  = 32'd11;
    mplier = 32'd13;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_add_b", 64'(add_b), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk("t6_no_done", 64'(seen), 64'd0);
    chk("t6_product", product, 64'd30);
`endif

    // Randomized operands against the reference multiply
    for (int n = 0; n < 24; n++) begin
      ra = $urandom();
      rb = $urandom();
      if (n == 0) ra = 32'h8000_0000;
      if (n == 1) rb = 32'h8000_0000;
      if (n == 2) rb = 32'h0;
      run_op(ra, rb, bc, seen);
      chk("rnd_done_seen", 64'(seen), 64'd1);
      chk("rnd_product", product, ref_mul(ra, rb));
      if (n[0]) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
